// File: rtl/neural_unit.sv
// neural_unit: single neuron. Four shift-weights, a serial weighted sum of four
// signed Q16.16 inputs, and an optional Elliot activation x/(1+|x|).
// Build option: define NEURAL_UNIT_ELLIOT_EN to include the ACT state and the
// restoring divider; without it layer_Sel is ignored and every result is raw.
module neural_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] input0,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic [31:0] input3,
  input  logic [7:0]  weight,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic        sumTrigger,
  input  logic        layer_Sel,
  output logic [31:0] layerOut,
  output logic        layerDone
);

  typedef enum logic [1:0] {IDLE, SUM, ACT, DONE} state_t;

  state_t            r_state, w_next;
  logic [3:0][7:0]   r_wbank;
  logic [3:0][7:0]   r_wsnap;
  logic [3:0][31:0]  r_xsnap;
  logic [1:0]        r_idx;
  logic [31:0]       r_acc;
  logic [31:0]       r_out;
  logic              r_done;

  logic [7:0]        w_w;
  logic [31:0]       w_x;
  logic signed [31:0] w_asr;
  logic [31:0]       w_shift;
  logic [31:0]       w_term;
  logic [31:0]       w_sum;
  logic              w_act_go;
  logic              w_unused;

`ifdef NEURAL_UNIT_ELLIOT_EN
  logic              r_sel;
  logic              r_neg;
  logic [32:0]       r_rem;
  logic [32:0]       r_div;
  logic [15:0]       r_q;
  logic [4:0]        r_cnt;
  logic [32:0]       w_mag;
  logic [33:0]       w_r2;
  logic              w_qbit;
  logic [15:0]       w_qfin;
  logic [31:0]       w_act_out;

  assign w_act_go = r_sel;
  assign w_unused = &{1'b0, r_wsnap[0][5], r_wsnap[1][5], r_wsnap[2][5], r_wsnap[3][5]};

  // Divider step: magnitude of the sum, one restoring iteration, signed result
  always_comb begin
    // 33-bit negate so that -2^31 yields a valid magnitude of 2^31
    w_mag     = r_acc[31] ? (33'd0 - {r_acc[31], r_acc}) : {1'b0, r_acc};
    w_r2      = {r_rem, 1'b0};
    w_qbit    = (w_r2 >= {1'b0, r_div});
    w_qfin    = {r_q[14:0], w_qbit};
    w_act_out = r_neg ? (32'd0 - {16'd0, w_qfin}) : {16'd0, w_qfin};
  end
`else
  assign w_act_go = 1'b0;
  assign w_unused = &{1'b0, layer_Sel, r_wsnap[0][5], r_wsnap[1][5], r_wsnap[2][5], r_wsnap[3][5]};
`endif

  // Current term: shift the selected input per its weight code, then negate
  always_comb begin
    w_w     = r_wsnap[r_idx];
    w_x     = r_xsnap[r_idx];
    w_asr   = $signed(w_x) >>> w_w[4:0];
    w_shift = w_w[6] ? w_asr : (w_x << w_w[4:0]);
    w_term  = w_w[7] ? (32'd0 - w_shift) : w_shift;
    w_sum   = r_acc + w_term;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (sumTrigger) w_next = SUM;
      SUM:  if (r_idx == 2'd3) w_next = w_act_go ? ACT : DONE;
`ifdef NEURAL_UNIT_ELLIOT_EN
      ACT:  if (r_cnt == 5'd16) w_next = DONE;
`else
      ACT:  w_next = DONE;
`endif
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Weight bank: writes accepted in any state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_wbank <= '0;
    else if (write) r_wbank[address] <= weight;
  end

  // Datapath: snapshot, accumulate, divide, publish result and done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wsnap <= '0;
      r_xsnap <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
`ifdef NEURAL_UNIT_ELLIOT_EN
      r_sel   <= 1'b0;
      r_neg   <= 1'b0;
      r_rem   <= '0;
      r_div   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
`endif
    end else begin
      r_done <= (w_next == DONE);
      case (r_state)
        IDLE: if (sumTrigger) begin
          // bank read here sees the pre-write value on a same-edge write
          r_xsnap <= {input3, input2, input1, input0};
          r_wsnap <= r_wbank;
          r_acc   <= '0;
          r_idx   <= '0;
`ifdef NEURAL_UNIT_ELLIOT_EN
          r_sel   <= layer_Sel;
          r_cnt   <= '0;
`endif
        end
        SUM: begin
          r_acc <= w_sum;
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3 && !w_act_go) r_out <= w_sum;
        end
`ifdef NEURAL_UNIT_ELLIOT_EN
        ACT: begin
          if (r_cnt == 5'd0) begin
            // setup: quotient of (A<<16)/(2^16+A) fits 16 bits since A < 2^16+A
            r_neg <= r_acc[31];
            r_rem <= w_mag;
            r_div <= 33'h1_0000 + w_mag;
            r_q   <= '0;
          end else begin
            r_rem <= w_qbit ? (w_r2[32:0] - r_div) : w_r2[32:0];
            r_q   <= w_qfin;
            if (r_cnt == 5'd16) r_out <= w_act_out;
          end
          r_cnt <= r_cnt + 5'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign layerOut  = r_out;
  assign layerDone = r_done;

endmodule

// File: tb/tb_neural_unit.sv
// Directed bench for neural_unit; expected values are hand-derived and follow
// the build option NEURAL_UNIT_ELLIOT_EN (activation on or off).
module tb_neural_unit;

`ifdef NEURAL_UNIT_ELLIOT_EN
  localparam bit ELL = 1'b1;
`else
  localparam bit ELL = 1'b0;
`endif
  localparam int LAT_ACT = ELL ? 21 : 4;

  logic        clk;
  logic        reset;
  logic [31:0] input0, input1, input2, input3;
  logic [7:0]  weight;
  logic [1:0]  address;
  logic        write;
  logic        sumTrigger;
  logic        layer_Sel;
  logic [31:0] layerOut;
  logic        layerDone;

  int errors = 0;
  int checks = 0;

  neural_unit dut (
    .clk(clk), .reset(reset),
    .input0(input0), .input1(input1), .input2(input2), .input3(input3),
    .weight(weight), .address(address), .write(write),
    .sumTrigger(sumTrigger), .layer_Sel(layer_Sel),
    .layerOut(layerOut), .layerDone(layerDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_w(input logic [1:0] a, input logic [7:0] c);
    write = 1'b1; address = a; weight = c;
    step();
    write = 1'b0;
  endtask

  task automatic set_w(input logic [7:0] c0, c1, c2, c3);
    write_w(2'd0, c0); write_w(2'd1, c1); write_w(2'd2, c2); write_w(2'd3, c3);
  endtask

  task automatic set_in(input logic [31:0] a, b, c, d);
    input0 = a; input1 = b; input2 = c; input3 = d;
  endtask

  // Trigger, scramble inputs after T0, wait for done; lat=-1 on timeout.
  task automatic run(input logic sel, output logic [31:0] res, output int lat,
                     output logic low_after);
    layer_Sel = sel; sumTrigger = 1'b1;
    step();
    sumTrigger = 1'b0; layer_Sel = ~sel;
    set_in(32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_0BAD);
    lat = -1; res = 32'hx; low_after = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (layerDone) begin lat = c; break; end
    end
    if (lat > 0) begin
      res = layerOut;
      step();
      low_after = ~layerDone;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    write = 0; weight = 0; address = 0; sumTrigger = 0; layer_Sel = 0;
    set_in(0, 0, 0, 0);
    repeat (3) step();
    checks++; if (layerOut !== 32'd0) begin errors++; $display("FAIL reset_out got=%h want=%h", layerOut, 32'd0); end
    checks++; if (layerDone !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", layerDone); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_act_small();
    logic [31:0] r; int l; logic lo;
    // terms 0,2,8,24 -> 34; elliot: 34*65536/65570 = 33.98 -> 0x21
    set_w(8'd0, 8'd1, 8'd2, 8'd3);
    set_in(0, 1, 2, 3);
    run(1'b1, r, l, lo);
    checks++; if (r !== (ELL ? 32'h21 : 32'h22)) begin errors++; $display("FAIL act_small_val got=%h want=%h", r, ELL ? 32'h21 : 32'h22); end
    checks++; if (l !== LAT_ACT) begin errors++; $display("FAIL act_small_lat got=%0d want=%0d", l, LAT_ACT); end
    checks++; if (lo !== 1'b1) begin errors++; $display("FAIL act_small_pulse got=%b want=1", lo); end
  endtask

  task automatic test_act_mid();
    logic [31:0] r; int l; logic lo;
    // terms 4,16,48,128 -> 196; elliot: 196*65536/65732 = 195.4 -> 0xC3
    set_w(8'd2, 8'd3, 8'd4, 8'd5);
    set_in(1, 2, 3, 4);
    run(1'b1, r, l, lo);
    checks++; if (r !== (ELL ? 32'hC3 : 32'hC4)) begin errors++; $display("FAIL act_mid_val got=%h want=%h", r, ELL ? 32'hC3 : 32'hC4); end
  endtask

  task automatic test_raw_sum();
    logic [31:0] r; int l; logic lo;
    // terms 16,96,512,2560 -> 3184 = 0xC70
    set_w(8'd3, 8'd5, 8'd7, 8'd9);
    set_in(2, 3, 4, 5);
    run(1'b0, r, l, lo);
    checks++; if (r !== 32'h0000_0C70) begin errors++; $display("FAIL raw_val got=%h want=%h", r, 32'h0C70); end
    checks++; if (l !== 4) begin errors++; $display("FAIL raw_lat got=%0d want=4", l); end
    checks++; if (lo !== 1'b1) begin errors++; $display("FAIL raw_pulse got=%b want=1", lo); end
    repeat (5) step();
    checks++; if (layerOut !== 32'h0000_0C70) begin errors++; $display("FAIL raw_hold got=%h want=%h", layerOut, 32'h0C70); end
  endtask

  task automatic test_negative();
    logic [31:0] r; int l; logic lo;
    // -1.0 -> elliot -0.5
    set_w(8'd0, 8'd0, 8'd0, 8'd0);
    set_in(32'hFFFF_0000, 0, 0, 0);
    run(1'b1, r, l, lo);
    checks++; if (r !== (ELL ? 32'hFFFF_8000 : 32'hFFFF_0000)) begin errors++; $display("FAIL neg_val got=%h want=%h", r, ELL ? 32'hFFFF_8000 : 32'hFFFF_0000); end
    // -2^31: magnitude 2^31, q = 2^31/32769 = 65534 -> -0xFFFE
    set_in(32'h8000_0000, 0, 0, 0);
    run(1'b1, r, l, lo);
    checks++; if (r !== (ELL ? 32'hFFFF_0002 : 32'h8000_0000)) begin errors++; $display("FAIL min_val got=%h want=%h", r, ELL ? 32'hFFFF_0002 : 32'h8000_0000); end
    checks++; if (l !== LAT_ACT) begin errors++; $display("FAIL min_lat got=%0d want=%0d", l, LAT_ACT); end
  endtask

  task automatic test_weight_codes();
    logic [31:0] r; int l; logic lo;
    logic [7:0]  codes [6] = '{8'h80, 8'h41, 8'hC2, 8'h21, 8'h44, 8'h01};
    logic [31:0] xin   [6] = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                               32'h0001_0000, 32'hFFFF_0000, 32'h8000_0000};
    logic [31:0] want  [6] = '{32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_C000,
                               32'h0002_0000, 32'hFFFF_F000, 32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      write_w(2'd0, codes[i]);
      set_in(xin[i], 0, 0, 0);
      run(1'b0, r, l, lo);
      checks++; if (r !== want[i]) begin errors++; $display("FAIL wcode_%0d got=%h want=%h", i, r, want[i]); end
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    logic [31:0] r; int l; logic lo;
    set_w(8'd1, 8'd1, 8'd1, 8'd1);
    set_in(7, 7, 7, 7);
    layer_Sel = 1'b1; sumTrigger = 1'b1;
    step();
    sumTrigger = 1'b0;
    repeat (ELL ? 7 : 2) step();
    reset = 1'b0; #1;
    checks++; if (layerOut !== 32'd0) begin errors++; $display("FAIL abort_out got=%h want=0", layerOut); end
    step();
    reset = 1'b1;
    seen = 1'b0;
    repeat (30) begin step(); if (layerDone) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_nodone got=%b want=0", seen); end
    // weights cleared -> plain sum 0x100+0x200+0x300+0x400
    set_in(32'h100, 32'h200, 32'h300, 32'h400);
    run(1'b0, r, l, lo);
    checks++; if (r !== 32'h0000_0A00) begin errors++; $display("FAIL abort_clear got=%h want=%h", r, 32'hA00); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int l; logic lo;
    // same-edge write+trigger snapshots old weight 0 -> x1
    set_in(5, 0, 0, 0);
    write = 1'b1; address = 2'd0; weight = 8'h01;
    run(1'b0, r, l, lo);
    write = 1'b0;
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL same_edge got=%h want=%h", r, 32'd5); end
    set_in(5, 0, 0, 0);
    run(1'b0, r, l, lo);
    checks++; if (r !== 32'd10) begin errors++; $display("FAIL b2b_new_w got=%h want=%h", r, 32'd10); end
    checks++; if (l !== 4) begin errors++; $display("FAIL b2b_lat got=%0d want=4", l); end
  endtask

  initial begin
    test_reset();
    test_act_small();
    test_act_mid();
    test_raw_sum();
    test_negative();
    test_weight_codes();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
